// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM encoding, timing
// derivation and ASCII codes used by the input subsystem.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [7:0] ASCII_SPACE = 8'd32;
    localparam logic [7:0] ASCII_CR    = 8'd13;
    localparam logic [7:0] ASCII_LF    = 8'd10;
    localparam logic [7:0] ASCII_ZERO  = 8'd48;

    function automatic int unsigned calc_cpb(
        input int unsigned clk_freq,
        input int unsigned baud
    );
        return clk_freq / baud;
    endfunction

    function automatic int unsigned calc_half(
        input int unsigned cpb
    );
        return cpb / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pins (serial lines, buttons).
// Reset value is configurable and defaults to all ones (idle-high lines).
module sync_2ff #(
    parameter int unsigned            WIDTH   = 1,
    parameter logic [WIDTH-1:0]       RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with one-cycle done / error strobes.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int unsigned CPB  = calc_cpb(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF = calc_half(CPB);

    localparam logic [15:0] CPB_M1  = 16'(CPB - 1);
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

    if (CPB < 4 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_byte_rx: CPB must be >= 4 and PARITY_ODD 0 or 1");
    end

    logic        rx_s;
    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  sr;
    // Cleared by a framing error so a held-low line (break) must
    // return high before another start bit is accepted.
    logic        armed;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    localparam logic ODD_BIT = (PARITY_ODD != 0);
    logic par_bad;
    logic par_err_q;

    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // Receive FSM: start qualification, data shift, stop check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            sr        <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            armed     <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            cnt       <= cnt + 16'd1;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt == CPB_M1) begin
                        cnt <= '0;
                        sr  <= {rx_s, sr[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == CPB_M1) begin
                        cnt     <= '0;
                        par_bad <= (rx_s != (^sr ^ ODD_BIT));
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == CPB_M1) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            armed     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            par_err_q <= 1'b1;
`endif
                        end else begin
                            rx_done <= 1'b1;
                            rx_data <= sr;
                        end
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
